// File: rtl/acc_pkg.sv
// Shared defaults and FSM encoding for the feature-tile feeder.
package acc_pkg;

  localparam int ACC_N      = 4;
  localparam int ACC_DATA_W = 8;
  localparam int ACC_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_skew.sv
// Triangular delay line: lane k delays its slice of the input vector by k+1 cycles.
module if_skew
  import acc_pkg::*;
#(
  parameter int N      = ACC_N,
  parameter int DATA_W = ACC_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid
);

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DATA_W-1:0] d_q [k+1];
    logic              v_q [k+1];

    // NOTE: the delay stages are cleared on reset (unlike plain storage) so a
    // tile aborted mid-flight cannot leak valid entries out after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= k; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        d_q[0] <= in_data[k*DATA_W +: DATA_W];
        v_q[0] <= in_valid;
        for (int i = 1; i <= k; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign out_data[k*DATA_W +: DATA_W] = d_q[k];
    assign out_valid[k]                 = v_q[k];
  end

endmodule

// File: rtl/if_feeder.sv
// Streams one feature tile from the FIFO into the array's left edge through a skew.
module if_feeder
  import acc_pkg::*;
#(
  parameter int N      = ACC_N,
  parameter int DATA_W = ACC_DATA_W,
  parameter int CNT_W  = ACC_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_if,
  input  logic [CNT_W-1:0]    num_rows,
  input  logic                src_valid,
  input  logic [N*DATA_W-1:0] src_data,
  output logic                src_rd,
  output logic [N*DATA_W-1:0] a_data,
  output logic [N-1:0]        a_valid,
  output logic                if_ready,
  output logic                if_done
);

  localparam int                 DRAIN_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(N - 1);

  if_state_e          state;
  logic [CNT_W-1:0]   rows_q;
  logic [CNT_W-1:0]   row_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [N*DATA_W-1:0] skew_data;

  // NOTE: src_rd is a continuous decode, not a register, so the FIFO pops in
  // the same cycle it presents data; rst gates it so nothing pops during reset.
  assign src_rd    = !rst && (state == STREAM) && src_valid;
  assign skew_data = src_rd ? src_data : '0;
  assign if_ready  = (state == IDLE);
  assign if_done   = !rst && (state == DRAIN) && (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_if) begin
            rows_q    <= num_rows;
            row_cnt   <= '0;
            drain_cnt <= '0;
            state     <= (num_rows == '0) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (src_valid) begin
            row_cnt <= row_cnt + CNT_W'(1);
            // Exact-equality end test; num_rows never exceeds the counter range.
            if (row_cnt + CNT_W'(1) == rows_q) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_skew #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk       (clk),
    .rst       (rst),
    .in_data   (skew_data),
    .in_valid  (src_rd),
    .out_data  (a_data),
    .out_valid (a_valid)
  );

endmodule
